bit_deserializer: RTL
=====================

// Module: bit_deserializer
// PURPOSE
//  Serial-to-parallel receiver; the inverse of the 32:1 select-tree used as a serializer.
//  Accepts one bit per valid/ready handshake and steers it into a word position.
//  A 5-to-32 one-hot decoder, driven by a bit-index counter, selects that position.
//  Presents each completed WIDTH-bit word on a registered valid/ready output port.
//  Sits between the serial link and the 32-bit datapath (register file write port / ALU operand).
// PARAMETERS
//  WIDTH      32  word width in bits; must be a power of 2
//  IDX_W      5   bit-index counter width; equals log2(WIDTH)
//  LSB_FIRST  1   1: k-th received bit -> word bit k; 0: k-th received bit -> word bit WIDTH-1-k
// PORTS
//  clk         in   1      single clock; all state updates on rising edge
//  reset_n     in   1      asynchronous, active-low reset
//  bit_in      in   1      serial data bit
//  bit_valid   in   1      bit_in is valid this cycle
//  bit_ready   out  1      block accepts bit_in this cycle
//  sync        in   1      synchronous frame restart; discards the partial word
//  word_out    out  WIDTH  assembled word (registered)
//  word_valid  out  1      word_out holds an unconsumed word
//  word_ready  in   1      downstream consumes word_out when word_valid=1
//  bit_idx     out  IDX_W  next bit position to be filled (0..WIDTH-1)
// BEHAVIOUR
//  Reset (async, reset_n=0): idx=0, assembly reg=0, word_out=0, word_valid=0.
//   bit_ready reads as 1 while in reset.
//  - Reset mid-word discards all partial and held data immediately.
//  Accept: bit_valid & bit_ready.
//   The decoder one-hot(idx, or WIDTH-1-idx when LSB_FIRST=0) enables exactly one assembly bit.
//   That bit loads bit_in; all other assembly bits hold.
//   idx then increments, wrapping WIDTH-1 -> 0.
//  bit_ready = !(idx==WIDTH-1 & word_valid & !word_ready).
//   Stall only when the final bit would need an output slot that is still occupied.
//   Ready has no combinational dependence on bit_valid.
//  Completion: accepting the bit at idx==WIDTH-1 causes, on the same edge:
//   - word_out <= assembly reg with that bit merged in; word_valid <= 1;
//   - assembly reg <= 0; idx <= 0.
//   Latency: word_valid rises 1 cycle after the last bit is accepted.
//  Output: word_valid & word_ready clears word_valid next cycle unless a new completion occurs that edge.
//   - Simultaneous consume + completion: word_out takes the new word and word_valid stays 1.
//   - Back-to-back words at 1 bit/cycle cause no stall when word_ready=1.
//   - word_out holds its value while word_valid=1 & !word_ready.
//   - word_out keeps its last value after it is consumed.
//  sync=1: idx <= 0 and assembly reg <= 0; word_out/word_valid are unaffected.
//   - sync with an accepted bit in the same cycle: the bit is written as position 0 of the new word;
//     idx <= 1 (or idx <= 0 with completion when WIDTH==1).
//   - sync overrides completion: a partial word never reaches word_out through sync.
//  Arithmetic: idx is an unsigned IDX_W counter and wraps naturally at WIDTH.
//  No overflow/drop path exists; upstream must honour bit_ready.
// STRUCTURE
//  Shared package (cpu_pkg):
//   - WORD_W=32 and WORD_IDX_W=5 constants.
//   - typedef word_t (logic [WORD_W-1:0]).
//   - LSB_FIRST default.
//  Sub-module onehot_decoder #(IDX_W): in sel[IDX_W-1:0], en; out dec[2**IDX_W-1:0].
//   - Combinational; dec = en ? (1<<sel) : 0.
//   - Built as a recursive 2->4->...->32 tree, mirroring the select tree.
//  This block holds: idx counter, assembly reg, output reg + valid, ready logic.
// TESTING
//  1 LSB_FIRST=1, word_ready=1: send 0xDEADBEEF bit0 first, 1 bit/cycle
//    -> word_out=0xDEADBEEF, word_valid=1 exactly 1 cycle after the 32nd accept; bit_idx=0.
//  2 LSB_FIRST=0: send 0x80000001 MSB first -> word_out=0x80000001.
//  3 Backpressure: word_ready=0 after word A=0x12345678; send 31 bits of B=0xCAFEF00D
//    -> bit_ready=1 until idx=31, then 0, with word_out=A held.
//    Raise word_ready -> same edge word_out=B, word_valid stays 1.
//  4 Back-to-back: 3 words (0x0, 0xFFFFFFFF, 0xA5A5A5A5), word_ready=1, 96 contiguous bits
//    -> 3 valid pulses 32 cycles apart, bit_ready never 0.
//  5 sync after 10 bits of junk, sync with the first bit of 0x00000001
//    -> word_out=0x00000001 after 32 accepts counted from the sync cycle; no junk word emitted.
//  6 reset_n pulsed low mid-word (idx=17) and while word_valid=1
//    -> word_valid=0, word_out=0, bit_idx=0 immediately; next full word is correct.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared datapath constants and types used by the serial receive path and the 32-bit core.
package cpu_pkg;

  localparam int WORD_W     = 32;
  localparam int WORD_IDX_W = 5;

  typedef logic [WORD_W-1:0] word_t;

  localparam bit LSB_FIRST_DEFAULT = 1'b1;

  // Word bit position that the k-th received bit lands in.
  function automatic logic [WORD_IDX_W-1:0] bit_pos(input logic [WORD_IDX_W-1:0] k,
                                                    input bit lsb_first);
    return lsb_first ? k : ~k;
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Recursive one-hot decoder: each level splits the enable on the top select bit,
// mirroring the 2->4->...->32 select tree of the serializer.
module onehot_decoder #(
  parameter int IDX_W = 5
) (
  input  logic [IDX_W-1:0]      sel,
  input  logic                  en,
  output logic [2**IDX_W-1:0]   dec
);

  generate
    if (IDX_W == 1) begin : g_leaf
      assign dec = {en & sel[0], en & ~sel[0]};
    end else begin : g_node
      localparam int HALF = 2**(IDX_W-1);
      logic w_en_lo;
      logic w_en_hi;

      assign w_en_lo = en & ~sel[IDX_W-1];
      assign w_en_hi = en &  sel[IDX_W-1];

      onehot_decoder #(.IDX_W(IDX_W-1)) u_lo (
        .sel (sel[IDX_W-2:0]),
        .en  (w_en_lo),
        .dec (dec[HALF-1:0])
      );

      onehot_decoder #(.IDX_W(IDX_W-1)) u_hi (
        .sel (sel[IDX_W-2:0]),
        .en  (w_en_hi),
        .dec (dec[2*HALF-1:HALF])
      );
    end
  endgenerate

endmodule

// File: rtl/bit_deserializer.sv
// Serial-to-parallel receiver: one bit per valid/ready handshake is steered into the
// assembly register by a one-hot decoder; completed words sit in a registered output slot.
module bit_deserializer
  import cpu_pkg::*;
#(
  parameter int WIDTH     = WORD_W,
  parameter int IDX_W     = WORD_IDX_W,
  parameter bit LSB_FIRST = LSB_FIRST_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             sync,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [IDX_W-1:0] bit_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH-1);

  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_asm;
  logic [WIDTH-1:0] r_word;
  logic             r_valid;

  logic [IDX_W-1:0] w_idx_eff;
  logic [IDX_W-1:0] w_sel;
  logic [WIDTH-1:0] w_dec;
  logic [WIDTH-1:0] w_asm_base;
  logic [WIDTH-1:0] w_asm_next;
  logic             w_accept;
  logic             w_complete;

  // Stall only when the final bit would need the output slot and that slot is still held.
  assign bit_ready = !((r_idx == LAST_IDX) && r_valid && !word_ready);
  assign w_accept  = bit_valid && bit_ready;

  // A sync restarts the frame this cycle, so an accompanying bit is position 0 of a new word.
  assign w_idx_eff  = sync ? '0 : r_idx;
  assign w_asm_base = sync ? '0 : r_asm;
  assign w_sel      = LSB_FIRST ? w_idx_eff : ~w_idx_eff;

  onehot_decoder #(.IDX_W(IDX_W)) u_dec (
    .sel (w_sel),
    .en  (w_accept),
    .dec (w_dec)
  );

  assign w_asm_next = (w_asm_base & ~w_dec) | (w_dec & {WIDTH{bit_in}});
  assign w_complete = w_accept && (w_idx_eff == LAST_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx   <= '0;
      r_asm   <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_complete) begin
        r_idx  <= '0;
        r_asm  <= '0;
        r_word <= w_asm_next;
      end else if (w_accept) begin
        r_idx <= w_idx_eff + 1'b1;
        r_asm <= w_asm_next;
      end else if (sync) begin
        r_idx <= '0;
        r_asm <= '0;
      end

      if (w_complete) begin
        r_valid <= 1'b1;
      end else if (r_valid && word_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign word_out   = r_word;
  assign word_valid = r_valid;
  assign bit_idx    = r_idx;

endmodule
